// File: rtl/execute_br_redirect.sv
`default_nettype none
// ============================================================================
// Module      : execute_br_redirect
// Description : Converts resolved taken branches from execute into a
//               registered fetch-redirect request and advances the epoch.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_br_redirect #(
    parameter int EPOCH_W = 2,
    parameter int REGSZ   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               input_valid,
    input  logic [EPOCH_W-1:0] in_epoch,
    input  logic               br_taken,
    input  logic [REGSZ-1:0]   br_dest,
    input  logic [REGSZ-1:0]   pc,
    input  logic               inst_lk,
    output logic               exe_stall,
    output logic               redirect_valid,
    input  logic               redirect_ready,
    output logic [REGSZ-1:0]   redirect_pc,
    output logic [EPOCH_W-1:0] redirect_epoch,
    output logic [EPOCH_W-1:0] cur_epoch,
    output logic               lr_valid,
    output logic [REGSZ-1:0]   lr_value
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PEND = 1'b1;

    logic [0:0]         r_state;
    logic               r_redirect_valid;
    logic [REGSZ-1:0]   r_redirect_pc;
    logic [EPOCH_W-1:0] r_redirect_epoch;
    logic [EPOCH_W-1:0] r_cur_epoch;
    logic               r_lr_valid;
    logic [REGSZ-1:0]   r_lr_value;

    logic               w_epoch_match;
    logic               w_stall;
    logic               w_acc;
    logic               w_take;
    logic               w_transfer;
    logic [EPOCH_W-1:0] w_next_epoch;
    logic [REGSZ-1:0]   w_target;
    logic [REGSZ-1:0]   w_link;
    logic               w_unused;

    // Tag mismatch marks a wrong-path instruction: it neither stalls nor acts.
    assign w_epoch_match = input_valid && (in_epoch == r_cur_epoch);
    assign w_stall       = (r_state == c_PEND) && !redirect_ready && w_epoch_match;
    assign w_acc         = w_epoch_match && !w_stall;
    assign w_take        = w_acc && br_taken;
    assign w_transfer    = r_redirect_valid && redirect_ready;
    assign w_next_epoch  = r_cur_epoch + EPOCH_W'(1);
    assign w_target      = {br_dest[REGSZ-1:2], 2'b00};
    assign w_link        = pc + REGSZ'(4);
    assign w_unused      = &{1'b0, br_dest[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_redirect_epoch <= '0;
            r_cur_epoch      <= '0;
            r_lr_valid       <= 1'b0;
            r_lr_value       <= '0;
        end else begin
            r_lr_valid <= w_acc && inst_lk;
            if (w_acc && inst_lk) begin
                r_lr_value <= w_link;
            end

            // A taken branch in PEND is only accepted when ready is high, so
            // reloading here implies the previous request has transferred.
            case (r_state)
                c_IDLE: begin
                    if (w_take) begin
                        r_state          <= c_PEND;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_target;
                        r_redirect_epoch <= w_next_epoch;
                        r_cur_epoch      <= w_next_epoch;
                    end
                end
                c_PEND: begin
                    if (w_take) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_target;
                        r_redirect_epoch <= w_next_epoch;
                        r_cur_epoch      <= w_next_epoch;
                    end else if (w_transfer) begin
                        r_state          <= c_IDLE;
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= c_IDLE;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    assign exe_stall      = w_stall;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign redirect_epoch = r_redirect_epoch;
    assign cur_epoch      = r_cur_epoch;
    assign lr_valid       = r_lr_valid;
    assign lr_value       = r_lr_value;

`ifdef SIM
    always @(posedge clk) begin
        if (input_valid === 1'b1 && ($isunknown(br_taken) || $isunknown(inst_lk))) begin
            $fatal(1, "execute_br_redirect: br_taken/inst_lk unknown while input_valid");
        end
    end
`endif

endmodule
`default_nettype wire
